// File: rtl/seq_divider_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package seq_divider_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int CNT_W_DEF = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Quotient reported when the divisor is zero.
   localparam logic [WIDTH_DEF-1:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_32b_if.sv
// Start/busy/done handshake and result bus between the ALU and the divider.
interface seq_divider_32b_if
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             sig_Z;
   logic             sig_DZ;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, sig_Z, sig_DZ
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, sig_Z, sig_DZ
   );

endinterface

// File: rtl/seq_divider_32b_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor
// through a ripple full-adder chain (A + ~B + 1), keep or restore on the carry-out.
module div_step
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH:0]   r_in,
   input  logic             q_bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   r_out,
   output logic             q_bit_out
);

   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   b_inv;
   logic [WIDTH:0]   diff;
   logic [WIDTH+1:0] carry;
   logic             unused_msb;

   // The partial remainder always stays below the divisor, so its top bit is shifted out.
   assign unused_msb = r_in[WIDTH];

   always_comb begin
      r_shift  = {r_in[WIDTH-1:0], q_bit_in};
      b_inv    = ~{1'b0, divisor};
      diff     = '0;
      carry    = '0;
      carry[0] = 1'b1;
      for (int i = 0; i <= WIDTH; i++) begin
         diff[i]      = r_shift[i] ^ b_inv[i] ^ carry[i];
         carry[i+1]   = (r_shift[i] & b_inv[i]) | (carry[i] & (r_shift[i] ^ b_inv[i]));
      end
      // Carry-out set means no borrow: the divisor fits and the difference is kept.
      q_bit_out = carry[WIDTH+1];
      r_out     = q_bit_out ? diff : r_shift;
   end

endmodule

// File: rtl/seq_divider_32b.sv
// Iterative unsigned restoring divider: one quotient bit per clock, WIDTH steps,
// with start/busy/done handshake and zero / divide-by-zero flags.
module seq_divider_32b
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic              clk,
   input logic              rst_n,
   seq_divider_32b_if.slave bus
);

   state_e           state_q, state_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             z_q, z_d;
   logic             dz_q, dz_d;

   logic [WIDTH:0]   step_r;
   logic             step_qbit;
   logic             accept;

   div_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .r_in      (r_q),
      .q_bit_in  (q_q[WIDTH-1]),
      .divisor   (dvs_q),
      .r_out     (step_r),
      .q_bit_out (step_qbit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         r_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         dvs_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         z_q     <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         dvs_q   <= dvs_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         z_q     <= z_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      dvs_d   = dvs_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      z_d     = z_q;
      dz_d    = dz_q;
      accept  = bus.start && (state_q != RUN);

      case (state_q)
         RUN: begin
            r_d   = step_r;
            q_d   = {q_q[WIDTH-2:0], step_qbit};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = DONE;
               quot_d  = q_d;
               rem_d   = step_r[WIDTH-1:0];
               z_d     = ~|q_d;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A new request in IDLE or DONE restarts the datapath; RUN ignores it.
      if (accept) begin
         q_d   = bus.dividend;
         r_d   = '0;
         cnt_d = '0;
         dvs_d = bus.divisor;
         z_d   = 1'b0;
         dz_d  = 1'b0;
         if (bus.divisor == '0) begin
            state_d = DONE;
            quot_d  = WIDTH'(DZ_QUOTIENT);
            rem_d   = bus.dividend;
            dz_d    = 1'b1;
         end else begin
            state_d = RUN;
         end
      end
   end

   assign bus.busy      = (state_q == RUN);
   assign bus.done      = (state_q == DONE);
   assign bus.quotient  = quot_q;
   assign bus.remainder = rem_q;
   assign bus.sig_Z     = z_q;
   assign bus.sig_DZ    = dz_q;

endmodule

// File: tb/tb_seq_divider_32b.sv
// Scoreboard bench for seq_divider_32b: expected results are queued at issue
// and popped when done is observed.
module tb_seq_divider_32b;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      logic         dz;
   } res_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   seq_divider_32b_if #(.WIDTH(W)) bus ();

   seq_divider_32b #(
      .WIDTH (W),
      .CNT_W (6)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   res_t sb[$];

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      res_t e;
      if (b == '0) begin
         e.q = '1; e.r = a; e.z = 1'b0; e.dz = 1'b1;
      end else begin
         e.q = a / b; e.r = a % b; e.z = (e.q == '0); e.dz = 1'b0;
      end
      return e;
   endfunction

   function automatic res_t got_res();
      return {bus.quotient, bus.remainder, bus.sig_Z, bus.sig_DZ};
   endfunction

   function automatic logic [W*2+3:0] all_outs();
      return {bus.busy, bus.done, bus.quotient, bus.remainder, bus.sig_Z, bus.sig_DZ};
   endfunction

   // Called at a falling edge; start is seen by the next rising edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input res_t e);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      sb.push_back(e);
      @(negedge clk);
      bus.start    = 1'b0;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
   endtask

   task automatic wait_done(output int cycles, output int busy_cyc);
      cycles   = 1;
      busy_cyc = 0;
      while (!bus.done && cycles < 100) begin
         if (bus.busy) busy_cyc++;
         @(negedge clk);
         cycles++;
      end
      if (!bus.done) cycles = -1;
   endtask

   task automatic test_reset();
      logic [W*2+3:0] o;
      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      o = all_outs();
      n_checks++;
      if (o !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", o); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      o = all_outs();
      n_checks++;
      if (o !== '0) begin n_fail++; $display("FAIL idle_after_reset got=%h exp=0", o); end
   endtask

   task automatic test_basic();
      int c, b;
      res_t got, exp;
      issue(100, 7, '{32'd14, 32'd2, 1'b0, 1'b0});
      wait_done(c, b);
      n_checks++;
      if (c != 33) begin n_fail++; $display("FAIL basic_latency got=%0d exp=33", c); end
      n_checks++;
      if (b != 32) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=32", b); end
      got = got_res(); exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL basic_result got=%h exp=%h", got, exp); end
      @(negedge clk);
      got = got_res();
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || got !== exp) begin
         n_fail++;
         $display("FAIL basic_hold done=%b busy=%b got=%h exp=%h", bus.done, bus.busy, got, exp);
      end
   endtask

   task automatic test_extremes();
      int c, b;
      res_t got, exp;
      issue(32'hFFFF_FFFF, 32'd1, '{32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0});
      wait_done(c, b);
      got = got_res(); exp = sb.pop_front();
      n_checks++;
      if (c != 33 || got !== exp) begin
         n_fail++; $display("FAIL max_div_one lat=%0d got=%h exp=%h", c, got, exp);
      end
      @(negedge clk);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'd1, 32'd0, 1'b0, 1'b0});
      wait_done(c, b);
      got = got_res(); exp = sb.pop_front();
      n_checks++;
      if (c != 33 || got !== exp) begin
         n_fail++; $display("FAIL max_div_max lat=%0d got=%h exp=%h", c, got, exp);
      end
   endtask

   task automatic test_zero_quotient();
      int c, b;
      res_t got, exp;
      issue(5, 10, '{32'd0, 32'd5, 1'b1, 1'b0});
      wait_done(c, b);
      got = got_res(); exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL zero_quotient got=%h exp=%h", got, exp); end
   endtask

   task automatic test_div_by_zero();
      int c, b;
      res_t got, exp;
      @(negedge clk);
      issue(1234, 0, '{32'hFFFF_FFFF, 32'd1234, 1'b0, 1'b1});
      wait_done(c, b);
      n_checks++;
      if (c != 1) begin n_fail++; $display("FAIL dz_latency got=%0d exp=1", c); end
      n_checks++;
      if (b != 0) begin n_fail++; $display("FAIL dz_busy got=%0d exp=0", b); end
      got = got_res(); exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL dz_result got=%h exp=%h", got, exp); end
   endtask

   task automatic test_start_ignored();
      int c;
      res_t got, exp;
      @(negedge clk);
      issue(100, 7, '{32'd14, 32'd2, 1'b0, 1'b0});
      c = 1;
      while (!bus.done && c < 100) begin
         if (c == 10) begin
            bus.start = 1'b1; bus.dividend = 9; bus.divisor = 3;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         c++;
      end
      bus.start = 1'b0;
      if (!bus.done) c = -1;
      got = got_res(); exp = sb.pop_front();
      n_checks++;
      if (c != 33 || got !== exp) begin
         n_fail++; $display("FAIL start_in_run lat=%0d got=%h exp=%h", c, got, exp);
      end
   endtask

   task automatic test_back_to_back();
      int c, b;
      res_t got, exp;
      @(negedge clk);
      issue(20, 6, '{32'd3, 32'd2, 1'b0, 1'b0});
      wait_done(c, b);
      got = got_res(); exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL b2b_first got=%h exp=%h", got, exp); end
      issue(9, 3, '{32'd3, 32'd0, 1'b0, 1'b0});
      wait_done(c, b);
      got = got_res(); exp = sb.pop_front();
      n_checks++;
      if (c != 33 || got !== exp) begin
         n_fail++; $display("FAIL b2b_second lat=%0d got=%h exp=%h", c, got, exp);
      end
      issue(7, 0, '{32'hFFFF_FFFF, 32'd7, 1'b0, 1'b1});
      wait_done(c, b);
      got = got_res(); exp = sb.pop_front();
      n_checks++;
      if (c != 1 || got !== exp) begin
         n_fail++; $display("FAIL b2b_dz lat=%0d got=%h exp=%h", c, got, exp);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [W*2+3:0] o;
      int seen;
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 100; bus.divisor = 7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (14) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 o = all_outs();
      n_checks++;
      if (o !== '0) begin n_fail++; $display("FAIL reset_mid_run got=%h exp=0", o); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.busy || bus.done) seen++;
      end
      n_checks++;
      if (seen != 0) begin n_fail++; $display("FAIL idle_after_abort got=%0d exp=0", seen); end
   endtask

   task automatic test_random();
      int c, b;
      logic [W-1:0] a, d;
      res_t got, exp;
      for (int i = 0; i < 8; i++) begin
         a = $urandom;
         d = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 15)) : W'($urandom >> $urandom_range(0, 31));
         @(negedge clk);
         issue(a, d, model(a, d));
         wait_done(c, b);
         got = got_res(); exp = sb.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL random_%0d a=%h d=%h got=%h exp=%h", i, a, d, got, exp);
         end
      end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
   endtask

   initial begin
      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      test_reset();
      test_basic();
      test_extremes();
      test_zero_quotient();
      test_div_by_zero();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_divider_32b.md
Name: seq_divider_32b

Overview:
- Iterative unsigned restoring divider for the 32-bit datapath. Produces quotient and remainder over WIDTH cycles.
- Each step performs one trial subtraction, computed as A + ~B + 1 on the ripple adder path. The carry-out of that subtraction is the restore/accept decision. The divider is the inverse-operation consumer of the adder's carry semantics.
- Sits beside the adder in the ALU. Takes operands through a start/busy/done handshake and reports Z and divide-by-zero status flags.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a division; sampled on the rising edge.
- dividend  input  WIDTH  numerator; sampled only when start is accepted.
- divisor  input  WIDTH  denominator; sampled only when start is accepted.
- busy  output  1  high while an iteration is in progress.
- done  output  1  one-cycle pulse marking valid results.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- sig_Z  output  1  quotient equals zero; valid with done and held afterwards.
- sig_DZ  output  1  divisor was zero; valid with done and held afterwards.

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-low (rst_n).
  - On reset: state=IDLE, busy=0, done=0, quotient=0, remainder=0, sig_Z=0, sig_DZ=0, counter=0.
- States: IDLE, RUN, DONE.
- Accepting start:
  - start is accepted only in IDLE or DONE. start in RUN is ignored; no queuing, in-flight operation unaffected.
  - On accept: latch the dividend into the quotient shift register Q, clear the partial remainder R (WIDTH+1 bits), clear the counter, clear sig_Z/sig_DZ.
  - If divisor==0: go to DONE directly with quotient=all ones, remainder=dividend, sig_DZ=1, sig_Z=0.
  - Otherwise go to RUN.
- RUN, one step per edge:
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - T = R' + ~{0,divisor} + 1, with carry-out c.
  - If c==1 (no borrow): R=T[WIDTH:0] and shift 1 into Q[0]. Else R=R' and shift 0 into Q[0].
  - Q shifts left each step. The counter increments.
- RUN to DONE: after exactly WIDTH steps (counter reaches WIDTH-1 on the step edge).
- Entering DONE:
  - quotient=Q and remainder=R[WIDTH-1:0] are registered.
  - sig_Z = (Q==0), evaluated as a NOR over all quotient bits.
- Timing:
  - Latency: start accepted at edge 0; done high in the cycle after edge WIDTH (33 clocks for WIDTH=32).
  - Divide-by-zero: done high in the cycle after edge 0.
- busy is 1 exactly while in RUN.
- done is 1 exactly while in DONE (one cycle). DONE goes to IDLE, or back to RUN/DONE if start is accepted in DONE (back-to-back issue allowed).
- Outputs quotient/remainder/sig_Z/sig_DZ hold their values until the next accepted start or reset.
- Reset mid-RUN aborts immediately to the reset values; no done is produced.
- Operands may change freely while busy; only the values at the accept edge matter.

Decomposition:
- Package seq_divider_pkg holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2),
  - the WIDTH default,
  - the all-ones divide-by-zero quotient constant.
- One combinational sub-module is natural: div_step. It takes R, the incoming Q bit, and the divisor, and returns the next R and the quotient bit. Internally it is a WIDTH+1-bit subtract via ~divisor with carry-in 1, reusing the full-adder cell chain.

Test Plan:
- dividend=100, divisor=7, start pulse -> busy for 32 cycles; done in cycle 33; quotient=14, remainder=2, sig_Z=0, sig_DZ=0.
- dividend=32'hFFFFFFFF, divisor=1 -> quotient=32'hFFFFFFFF, remainder=0. Then divisor=32'hFFFFFFFF, same dividend -> quotient=1, remainder=0.
- dividend=5, divisor=10 -> quotient=0, remainder=5, sig_Z=1.
- dividend=1234, divisor=0 -> done in cycle after accept; quotient=32'hFFFFFFFF, remainder=1234, sig_DZ=1, busy never high.
- Start 100/7, then start again at cycle 10 with 9/3 -> second start ignored; results 14/2. Start in the done cycle with 9/3 -> accepted, results 3/0 after 33 cycles.
- Start 100/7, assert rst_n=0 at cycle 15 (between edges) -> busy/done/quotient/remainder/flags all 0 immediately. After release, idle until a new start.
